riscv_ifu: RTL and testbench

RISCV_IFU -- requirements
Module: riscv_ifu

---
 rtl/riscv_pkg.sv | 8 +
 rtl/riscv_ifu_fifo.sv | 40 ++++
 rtl/riscv_ifu.sv | 80 ++++++++
 tb/tb_riscv_ifu.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared reset PC and fetch-buffer entry type for the instruction fetch unit
package riscv_pkg;
  localparam logic [63:0] RESET_PC = 64'h0;
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/riscv_ifu_fifo.sv
// riscv_ifu_fifo: 2-entry fetch buffer (push, pop, flush, count, head)
module riscv_ifu_fifo import riscv_pkg::*; #(
  parameter int W = $bits(fetch_entry_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic rd_q, rd_d, wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    rd_d  = flush ? 1'b0 : rd_q ^ pop;
    wr_d  = flush ? 1'b0 : wr_q ^ push;
    cnt_d = flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    count = cnt_q;
    head  = mem_q[rd_q];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/riscv_ifu.sv
// riscv_ifu: credit-based instruction fetch unit feeding ID through a 2-entry buffer; RISCV_IFU_MISALIGN_CHK_EN halts on misaligned redirects
module riscv_ifu import riscv_pkg::*; #(
  parameter int IBUS_DATA_WIDTH = 32,
  parameter int DBUS_DATA_WIDTH = 64,
  parameter int IMEM_ADDR_WIDTH = 12,
  parameter logic [DBUS_DATA_WIDTH-1:0] RESET_PC = DBUS_DATA_WIDTH'(riscv_pkg::RESET_PC)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sft_rst,
  output logic                       imem_cs,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [IBUS_DATA_WIDTH-1:0] imem_rd_data,
  input  logic                       redirect_valid,
  input  logic [DBUS_DATA_WIDTH-1:0] redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [IBUS_DATA_WIDTH-1:0] id_instr,
  output logic [DBUS_DATA_WIDTH-1:0] id_pc,
  output logic                       fetch_err
);
  localparam int EW = IBUS_DATA_WIDTH + DBUS_DATA_WIDTH;
  logic [DBUS_DATA_WIDTH-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, tgt_pc, fetch_pc;
  logic pend_q, pend_d, halt, pop, push, flush;
  logic [1:0] count;
  logic [EW-1:0] head;
`ifdef RISCV_IFU_MISALIGN_CHK_EN
  logic err_q, err_d, bad;
  assign tgt_pc    = redirect_pc;
  assign bad       = redirect_valid & |redirect_pc[1:0];
  assign halt      = err_q | bad;
  assign err_d     = ~sft_rst & (err_q | bad);
  assign fetch_err = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign tgt_pc    = {redirect_pc[DBUS_DATA_WIDTH-1:2], 2'b00};
  assign halt      = 1'b0;
  assign fetch_err = 1'b0;
`endif
  always_comb begin
    fetch_pc  = redirect_valid ? tgt_pc : pc_q;
    id_valid  = (count != 2'd0) & ~redirect_valid & ~sft_rst;
    pop       = id_valid & id_ready;
    // credit: buffered + in-flight - leaving this cycle must leave room for one more
    imem_cs   = rst_n & ~halt & ~sft_rst &
                (redirect_valid | ((3'(count) + 3'(pend_q) - 3'(pop)) < 3'd2));
    push      = pend_q & ~redirect_valid & ~sft_rst;
    flush     = redirect_valid | sft_rst;
    pc_d      = sft_rst ? RESET_PC : imem_cs ? fetch_pc + DBUS_DATA_WIDTH'(4) : pc_q;
    pend_d    = imem_cs;
    pend_pc_d = imem_cs ? fetch_pc : pend_pc_q;
    imem_addr = fetch_pc[IMEM_ADDR_WIDTH+1:2];
    id_instr  = head[DBUS_DATA_WIDTH +: IBUS_DATA_WIDTH];
    id_pc     = head[DBUS_DATA_WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end
  riscv_ifu_fifo #(.W(EW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({imem_rd_data, pend_pc_q}),
    .count (count),
    .head  (head)
  );
endmodule

// File: tb/tb_riscv_ifu.sv
// tb_riscv_ifu: directed self-checking bench for riscv_ifu
module tb_riscv_ifu;
  logic clk = 1'b0, rst_n = 1'b0, sft_rst = 1'b0, redirect_valid = 1'b0, id_ready = 1'b1;
  logic [63:0] redirect_pc = '0;
  logic [31:0] imem_rd_data = '0;
  logic imem_cs, id_valid, fetch_err;
  logic [11:0] imem_addr;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  int n_cmp = 0, n_err = 0;
  riscv_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sft_rst        (sft_rst),
    .imem_cs        (imem_cs),
    .imem_addr      (imem_addr),
    .imem_rd_data   (imem_rd_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .fetch_err      (fetch_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) imem_rd_data <= imem_cs ? (32'hA000_0000 | {20'h0, imem_addr}) : 32'hDEAD_BEEF;
  function automatic logic [31:0] ins(input logic [63:0] pc);
    return 32'hA000_0000 | {20'h0, pc[13:2]};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  initial begin
    repeat (2) cyc();
    chk("rst_cs", 64'(imem_cs), 0);
    chk("rst_valid", 64'(id_valid), 0);
    chk("rst_err", 64'(fetch_err), 0);
    rst_n = 1'b1; #1;
    chk("c0_cs", 64'(imem_cs), 1);
    chk("c0_addr", 64'(imem_addr), 0);
    cyc();
    chk("c1_valid", 64'(id_valid), 0);
    chk("c1_addr", 64'(imem_addr), 1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("stream_valid", 64'(id_valid), 1);
      chk("stream_pc", id_pc, 64'(k * 4));
      chk("stream_instr", 64'(id_instr), 64'(ins(64'(k * 4))));
    end
    cyc(); sft_rst = 1'b1; id_ready = 1'b0; #1;
    chk("srst_cs", 64'(imem_cs), 0);
    chk("srst_valid", 64'(id_valid), 0);
    cyc(); sft_rst = 1'b0; #1;
    chk("r0_cs", 64'(imem_cs), 1);
    chk("r0_addr", 64'(imem_addr), 0);
    cyc();
    chk("r1_cs", 64'(imem_cs), 1);
    chk("r1_addr", 64'(imem_addr), 1);
    chk("r1_valid", 64'(id_valid), 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_cs", 64'(imem_cs), 0);
      chk("stall_valid", 64'(id_valid), 1);
      chk("stall_pc", id_pc, 0);
    end
    cyc(); id_ready = 1'b1; #1;
    chk("rel_pc", id_pc, 0);
    chk("rel_cs", 64'(imem_cs), 1);
    chk("rel_addr", 64'(imem_addr), 2);
    for (int k = 1; k < 4; k++) begin
      cyc();
      chk("rel_stream_valid", 64'(id_valid), 1);
      chk("rel_stream_pc", id_pc, 64'(k * 4));
    end
    cyc(); id_ready = 1'b0; #1;
    chk("full_pc", id_pc, 64'h10);
    chk("full_cs", 64'(imem_cs), 0);
    cyc();
    chk("full2_pc", id_pc, 64'h10);
    redirect_valid = 1'b1; redirect_pc = 64'h100; #1;
    chk("redir_valid", 64'(id_valid), 0);
    chk("redir_cs", 64'(imem_cs), 1);
    chk("redir_addr", 64'(imem_addr), 64'h40);
    cyc(); redirect_valid = 1'b0; id_ready = 1'b1; #1;
    chk("redir1_valid", 64'(id_valid), 0);
    chk("redir1_addr", 64'(imem_addr), 64'h41);
    cyc();
    chk("redir2_valid", 64'(id_valid), 1);
    chk("redir2_pc", id_pc, 64'h100);
    chk("redir2_instr", 64'(id_instr), 64'(ins(64'h100)));
    cyc();
    chk("redir3_pc", id_pc, 64'h104);
    cyc(); redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    chk("wrap_addr", 64'(imem_addr), 64'hFFF);
    cyc(); redirect_valid = 1'b0; #1;
    chk("wrap1_valid", 64'(id_valid), 0);
    chk("wrap1_addr", 64'(imem_addr), 0);
    cyc();
    chk("wrap2_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap2_instr", 64'(id_instr), 64'h0000_0000_A000_0FFF);
    cyc();
    chk("wrap3_pc", id_pc, 0);
    chk("wrap3_instr", 64'(id_instr), 64'h0000_0000_A000_0000);
    cyc(); redirect_valid = 1'b1; redirect_pc = 64'h102; #1;
`ifdef RISCV_IFU_MISALIGN_CHK_EN
    chk("mis_cs", 64'(imem_cs), 0);
    chk("mis_valid", 64'(id_valid), 0);
    cyc(); redirect_valid = 1'b0; #1;
    chk("mis1_err", 64'(fetch_err), 1);
    chk("mis1_cs", 64'(imem_cs), 0);
    chk("mis1_valid", 64'(id_valid), 0);
    cyc();
    chk("mis2_err", 64'(fetch_err), 1);
    chk("mis2_cs", 64'(imem_cs), 0);
    cyc(); sft_rst = 1'b1; #1;
    cyc(); sft_rst = 1'b0; #1;
    chk("mis_clr_err", 64'(fetch_err), 0);
    chk("mis_clr_cs", 64'(imem_cs), 1);
    chk("mis_clr_addr", 64'(imem_addr), 0);
`else
    chk("mis_cs", 64'(imem_cs), 1);
    chk("mis_addr", 64'(imem_addr), 64'h40);
    chk("mis_err", 64'(fetch_err), 0);
    cyc(); redirect_valid = 1'b0; #1;
    cyc();
    chk("mis_pc", id_pc, 64'h100);
    chk("mis_valid", 64'(id_valid), 1);
`endif
    cyc(); cyc();
    chk("pre_arst_valid", 64'(id_valid), 1);
    #2; rst_n = 1'b0; #1;
    chk("arst_valid", 64'(id_valid), 0);
    chk("arst_cs", 64'(imem_cs), 0);
    cyc(); cyc();
    chk("arst_hold_valid", 64'(id_valid), 0);
    rst_n = 1'b1; #1;
    chk("arst_rel_cs", 64'(imem_cs), 1);
    chk("arst_rel_addr", 64'(imem_addr), 0);
    cyc(); cyc();
    chk("arst_restart_valid", 64'(id_valid), 1);
    chk("arst_restart_pc", id_pc, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
